instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 150 +++++++++++++++
 tb/tb_instr_fetch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: takes a PC, issues one instruction-memory read and
// presents the returned word (or a misalignment error) to decode.
module instr_fetch #(
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] PC_IN,
  input  logic        PC_VALID,
  output logic        PC_READY,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_GNT,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] INST_OUT,
  output logic [31:0] INST_PC,
  output logic        INST_VALID,
  output logic        INST_ERR,
  input  logic        INST_READY,
  input  logic        FLUSH
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_d;
  logic        mem_req_d;
  logic [31:0] inst_out_d;
  logic [31:0] inst_pc_d;
  logic        inst_valid_d;
  logic        inst_err_d;
  logic        accept;
  logic        launch;

  // Reset is folded in so upstream never sees a ready while the block is held in reset.
  assign PC_READY = !Reset && !FLUSH &&
                    ((state_q == S_IDLE) || ((state_q == S_HOLD) && INST_READY));
  assign accept   = PC_VALID && PC_READY;

  // NOTE: every variable written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = MEM_ADDR;
    mem_req_d    = MEM_REQ;
    inst_out_d   = INST_OUT;
    inst_pc_d    = INST_PC;
    inst_valid_d = INST_VALID;
    inst_err_d   = INST_ERR;
    launch       = 1'b0;

    if (FLUSH) begin
      mem_req_d = 1'b0;
      unique case (state_q)
        S_REQ:   state_d = MEM_GNT ? S_DRAIN : S_IDLE;
        S_WAIT:  state_d = MEM_RVALID ? S_IDLE : S_DRAIN;
        S_HOLD: begin
          state_d      = S_IDLE;
          inst_valid_d = 1'b0;
          inst_err_d   = 1'b0;
          inst_out_d   = NOP_INST;
        end
        S_DRAIN: state_d = S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: launch = accept;
        S_REQ: begin
          if (MEM_GNT) begin
            state_d   = S_WAIT;
            mem_req_d = 1'b0;
          end
        end
        S_WAIT: begin
          if (MEM_RVALID) begin
            state_d      = S_HOLD;
            inst_out_d   = MEM_RDATA;
            inst_pc_d    = MEM_ADDR;
            inst_err_d   = 1'b0;
            inst_valid_d = 1'b1;
          end
        end
        S_HOLD: begin
          if (INST_READY) begin
            if (accept) begin
              launch = 1'b1;
            end else begin
              state_d      = S_IDLE;
              inst_valid_d = 1'b0;
              inst_err_d   = 1'b0;
              inst_out_d   = NOP_INST;
            end
          end
        end
        S_DRAIN: begin
          if (MEM_RVALID) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A misaligned PC never reaches memory; it is reported straight to decode.
    if (launch) begin
      addr_d = PC_IN;
      if (PC_IN[1:0] == 2'b00) begin
        state_d      = S_REQ;
        mem_req_d    = 1'b1;
        inst_valid_d = 1'b0;
        inst_err_d   = 1'b0;
        inst_out_d   = NOP_INST;
      end else begin
        state_d      = S_HOLD;
        mem_req_d    = 1'b0;
        inst_out_d   = NOP_INST;
        inst_pc_d    = PC_IN;
        inst_err_d   = 1'b1;
        inst_valid_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      MEM_REQ    <= 1'b0;
      MEM_ADDR   <= 32'h0;
      INST_OUT   <= NOP_INST;
      INST_PC    <= 32'h0;
      INST_VALID <= 1'b0;
      INST_ERR   <= 1'b0;
    end else begin
      state_q    <= state_d;
      MEM_REQ    <= mem_req_d;
      MEM_ADDR   <= addr_d;
      INST_OUT   <= inst_out_d;
      INST_PC    <= inst_pc_d;
      INST_VALID <= inst_valid_d;
      INST_ERR   <= inst_err_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table-driven fetches scored through a
// queue, plus hand-written flush and reset sequences.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          gnt_dly;
    int          rv_dly;
    int          stall;
  } fetch_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] PC_IN;
  logic        PC_VALID;
  logic        PC_READY;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_GNT;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;
  logic [31:0] INST_OUT;
  logic [31:0] INST_PC;
  logic        INST_VALID;
  logic        INST_ERR;
  logic        INST_READY;
  logic        FLUSH;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t got;

  instr_fetch #(.NOP_INST(NOP)) dut (
    .CLK(CLK), .Reset(Reset), .PC_IN(PC_IN), .PC_VALID(PC_VALID), .PC_READY(PC_READY),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID),
    .MEM_RDATA(MEM_RDATA), .INST_OUT(INST_OUT), .INST_PC(INST_PC), .INST_VALID(INST_VALID),
    .INST_ERR(INST_ERR), .INST_READY(INST_READY), .FLUSH(FLUSH)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: every instruction decode consumes must match the oldest expectation.
  always @(negedge CLK) begin
    if (!Reset && INST_VALID && INST_READY && !FLUSH) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got inst %h pc %h with nothing expected", INST_OUT, INST_PC);
      end else begin
        got = sb.pop_front();
        check("sb_inst_out", INST_OUT, got.inst);
        check("sb_inst_pc", INST_PC, got.pc);
        check("sb_inst_err", {31'b0, INST_ERR}, {31'b0, got.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic fetch(input fetch_t f);
    exp_t e;
    bit   aligned;
    int   n;
    aligned    = (f.pc[1:0] == 2'b00);
    PC_IN      = f.pc;
    PC_VALID   = 1'b1;
    INST_READY = 1'b1;
    n = 0;
    #1;
    while (!PC_READY && n < 20) begin
      tick();
      #1;
      n++;
    end
    if (!PC_READY) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pc %h never accepted", f.pc);
      PC_VALID = 1'b0;
      return;
    end
    e.inst = aligned ? f.data : NOP;
    e.pc   = f.pc;
    e.err  = !aligned;
    sb.push_back(e);
    tick();
    PC_VALID   = 1'b0;
    INST_READY = 1'b0;
    if (aligned) begin
      check("mem_req_issue", {31'b0, MEM_REQ}, 32'd1);
      check("mem_addr_issue", MEM_ADDR, f.pc);
      for (int i = 0; i < f.gnt_dly; i++) begin
        tick();
        check("mem_req_hold", {31'b0, MEM_REQ}, 32'd1);
        check("mem_addr_hold", MEM_ADDR, f.pc);
      end
      MEM_GNT = 1'b1;
      tick();
      MEM_GNT = 1'b0;
      check("mem_req_drop", {31'b0, MEM_REQ}, 32'd0);
      for (int i = 1; i < f.rv_dly; i++) begin
        check("inst_valid_wait", {31'b0, INST_VALID}, 32'd0);
        tick();
      end
      MEM_RVALID = 1'b1;
      MEM_RDATA  = f.data;
      tick();
      MEM_RVALID = 1'b0;
      MEM_RDATA  = 32'hBAD0BAD0;
    end else begin
      check("mem_req_misalign", {31'b0, MEM_REQ}, 32'd0);
    end
    check("hold_valid", {31'b0, INST_VALID}, 32'd1);
    check("hold_out", INST_OUT, e.inst);
    check("hold_pc", INST_PC, e.pc);
    check("hold_err", {31'b0, INST_ERR}, {31'b0, e.err});
    for (int i = 0; i < f.stall; i++) begin
      tick();
      check("stall_valid", {31'b0, INST_VALID}, 32'd1);
      check("stall_out", INST_OUT, e.inst);
      check("stall_pc", INST_PC, e.pc);
      #1;
      check("stall_pc_ready", {31'b0, PC_READY}, 32'd0);
    end
  endtask

  task automatic accept_pc(input logic [31:0] pc);
    PC_IN    = pc;
    PC_VALID = 1'b1;
    #1;
    check("accept_ready", {31'b0, PC_READY}, 32'd1);
    tick();
    PC_VALID = 1'b0;
  endtask

  fetch_t vec[6];

  initial begin
    vec[0] = '{32'h00000040, 32'h8C010004, 0, 2, 5};
    vec[1] = '{32'h00000044, 32'h00A00093, 0, 1, 0};
    vec[2] = '{32'h00000042, 32'hFFFFFFFF, 0, 1, 2};
    vec[3] = '{32'h00000048, 32'hDEADBEEF, 3, 4, 1};
    vec[4] = '{32'h0000004C, 32'h12345678, 1, 1, 0};
    vec[5] = '{32'h00000051, 32'h0, 0, 1, 1};

    Reset = 1'b1; PC_IN = '0; PC_VALID = 1'b0; MEM_GNT = 1'b0; MEM_RVALID = 1'b0;
    MEM_RDATA = '0; INST_READY = 1'b0; FLUSH = 1'b0;
    #3;
    check("rst_mem_req", {31'b0, MEM_REQ}, 32'd0);
    check("rst_mem_addr", MEM_ADDR, 32'h0);
    check("rst_inst_valid", {31'b0, INST_VALID}, 32'd0);
    check("rst_inst_err", {31'b0, INST_ERR}, 32'd0);
    check("rst_inst_pc", INST_PC, 32'h0);
    check("rst_inst_out", INST_OUT, NOP);
    check("rst_pc_ready", {31'b0, PC_READY}, 32'd0);
    tick();
    tick();
    Reset = 1'b0;
    #1;
    check("idle_pc_ready", {31'b0, PC_READY}, 32'd1);

    foreach (vec[i]) fetch(vec[i]);
    INST_READY = 1'b1;
    tick();
    tick();
    check("drain_idle_valid", {31'b0, INST_VALID}, 32'd0);
    check("drain_idle_out", INST_OUT, NOP);

    // Flush in REQ without grant: straight back to idle, address kept.
    accept_pc(32'h000000A0);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("flushreq_mem_req", {31'b0, MEM_REQ}, 32'd0);
    check("flushreq_mem_addr", MEM_ADDR, 32'h000000A0);
    #1;
    check("flushreq_pc_ready", {31'b0, PC_READY}, 32'd1);

    // Flush one cycle after grant: response arrives in DRAIN and is dropped.
    accept_pc(32'h00000080);
    MEM_GNT = 1'b1;
    tick();
    MEM_GNT = 1'b0;
    FLUSH   = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("flushwait_mem_req", {31'b0, MEM_REQ}, 32'd0);
    check("flushwait_valid", {31'b0, INST_VALID}, 32'd0);
    #1;
    check("flushwait_drain_ready", {31'b0, PC_READY}, 32'd0);
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'h0BADF00D;
    tick();
    MEM_RVALID = 1'b0;
    check("flushwait_after_valid", {31'b0, INST_VALID}, 32'd0);
    check("flushwait_after_out", INST_OUT, NOP);
    #1;
    check("flushwait_after_ready", {31'b0, PC_READY}, 32'd1);

    // Flush together with grant: DRAIN, then a fresh fetch completes normally.
    accept_pc(32'h00000090);
    MEM_GNT = 1'b1;
    FLUSH   = 1'b1;
    tick();
    MEM_GNT = 1'b0;
    FLUSH   = 1'b0;
    check("flushgnt_mem_req", {31'b0, MEM_REQ}, 32'd0);
    #1;
    check("flushgnt_drain_ready", {31'b0, PC_READY}, 32'd0);
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'h0DEAD000;
    tick();
    MEM_RVALID = 1'b0;
    check("flushgnt_valid", {31'b0, INST_VALID}, 32'd0);
    fetch('{32'h00000100, 32'h00108093, 1, 1, 0});
    INST_READY = 1'b1;
    tick();
    check("flushgnt_consumed", {31'b0, INST_VALID}, 32'd0);

    // Flush in HOLD with decode ready: held word is dropped, not consumed.
    INST_READY = 1'b0;
    accept_pc(32'h000000B1);
    check("flushhold_err", {31'b0, INST_ERR}, 32'd1);
    check("flushhold_pc", INST_PC, 32'h000000B1);
    INST_READY = 1'b1;
    FLUSH      = 1'b1;
    #1;
    check("flushhold_ready", {31'b0, PC_READY}, 32'd0);
    tick();
    FLUSH = 1'b0;
    check("flushhold_valid", {31'b0, INST_VALID}, 32'd0);
    check("flushhold_out", INST_OUT, NOP);

    // Asynchronous reset between edges while waiting for data.
    accept_pc(32'h000000C0);
    MEM_GNT = 1'b1;
    tick();
    MEM_GNT = 1'b0;
    #3;
    Reset = 1'b1;
    #1;
    check("areset_mem_req", {31'b0, MEM_REQ}, 32'd0);
    check("areset_mem_addr", MEM_ADDR, 32'h0);
    check("areset_valid", {31'b0, INST_VALID}, 32'd0);
    check("areset_out", INST_OUT, NOP);
    check("areset_pc_ready", {31'b0, PC_READY}, 32'd0);
    tick();
    Reset      = 1'b0;
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'h0FEEDBAC;
    tick();
    MEM_RVALID = 1'b0;
    check("late_rvalid_valid", {31'b0, INST_VALID}, 32'd0);
    check("late_rvalid_out", INST_OUT, NOP);
    #1;
    check("late_rvalid_ready", {31'b0, PC_READY}, 32'd1);

    tick();
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
